// File: rtl/systolic_array_4x4_pkg.sv
// Shared constants and FSM state encoding for the 4x4 output-stationary MAC array.
package systolic_array_4x4_pkg;

  localparam int W_DEF        = 32;
  localparam int FEED_CYCLES  = 7;
  localparam int DRAIN_CYCLES = 7;
  localparam int CNT_W        = 6;
  localparam int N            = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/systolic_array_4x4_pe.sv
// One processing element: registers a/b for its neighbours and accumulates a*b.
// Latency 1 cycle per hop; no backpressure, the array advances every cycle.
module systolic_array_4x4_pe
  import systolic_array_4x4_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] a_left,
  input  logic [W-1:0] b_up,
  output logic [W-1:0] a_reg,
  output logic [W-1:0] b_reg,
  output logic [W-1:0] acc
);

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] prod;

  // Product and sum both wrap mod 2^W, so unsigned and two's complement agree.
  assign prod = a_left * b_up;

  always_comb begin
    a_d   = a_left;
    b_d   = b_up;
    acc_d = acc_q + prod;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_reg = a_q;
  assign b_reg = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_array_4x4.sv
// Sequences two drippers and accumulates C = A x B in a 4x4 PE grid; done after 16 cycles.
// Results are held with done until ack; start in DONE restarts directly.
module systolic_array_4x4
  import systolic_array_4x4_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              drip_load,
  output logic [CNT_W-1:0]  drip_count,
  input  logic [4*W-1:0]    a_in,
  input  logic [4*W-1:0]    b_in,
  output logic              busy,
  output logic              done,
  input  logic              ack,
  output logic [16*W-1:0]   c_out
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] drip_count_q, drip_count_d;
  logic             drip_load_q, drip_load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_en_q, in_en_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_FEED;
        phase_d = CNT_W'(1);
      end
      ST_FEED: begin
        if (phase_q == CNT_W'(FEED_CYCLES)) begin
          state_d = ST_DRAIN;
          phase_d = CNT_W'(1);
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (phase_q == CNT_W'(DRAIN_CYCLES)) begin
          state_d = ST_DONE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (start)    state_d = ST_LOAD;
        else if (ack) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so they are registered with it.
    drip_load_d  = (state_d == ST_LOAD);
    drip_count_d = (state_d == ST_FEED) ? phase_d : '0;
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_FEED) || (state_d == ST_DRAIN);
    done_d       = (state_d == ST_DONE);
    // Dripper outputs lag their count by one cycle.
    in_en_d      = (drip_count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      drip_count_q <= '0;
      drip_load_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      in_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      drip_count_q <= drip_count_d;
      drip_load_q  <= drip_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      in_en_q      <= in_en_d;
    end
  end

  assign drip_load  = drip_load_q;
  assign drip_count = drip_count_q;
  assign busy       = busy_q;
  assign done       = done_q;

  logic [W-1:0] a_pass [N][N];
  logic [W-1:0] b_pass [N][N];
  logic [W-1:0] acc    [N][N];

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [W-1:0] a_left;
      logic [W-1:0] b_up;

      if (gj == 0) begin : g_a_edge
        assign a_left = in_en_q ? a_in[gi*W +: W] : '0;
      end else begin : g_a_inner
        assign a_left = a_pass[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_up = in_en_q ? b_in[gj*W +: W] : '0;
      end else begin : g_b_inner
        assign b_up = b_pass[gi-1][gj];
      end

      systolic_array_4x4_pe #(.W(W)) u_pe (
        .clk    (clk),
        .rst    (rst),
        .clr    (drip_load_q),
        .a_left (a_left),
        .b_up   (b_up),
        .a_reg  (a_pass[gi][gj]),
        .b_reg  (b_pass[gi][gj]),
        .acc    (acc[gi][gj])
      );

      assign c_out[(N*gi+gj)*W +: W] = acc[gi][gj];
    end
  end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Bench for systolic_array_4x4: behavioural drippers feed random and directed
// matrices; results are compared against a plain matrix-product reference.
module tb_systolic_array_4x4;
  import systolic_array_4x4_pkg::*;

  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              ack = 1'b0;
  logic              drip_load;
  logic [CNT_W-1:0]  drip_count;
  logic [4*DW-1:0]   a_in = '0;
  logic [4*DW-1:0]   b_in = '0;
  logic              busy;
  logic              done;
  logic [16*DW-1:0]  c_out;

  logic [DW-1:0] ma [4][4];
  logic [DW-1:0] mb [4][4];
  logic [DW-1:0] la [4][4];
  logic [DW-1:0] lb [4][4];
  logic [DW-1:0] ref_c [4][4];

  int vectors = 0;
  int miscompares = 0;

  systolic_array_4x4 #(.W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .drip_load  (drip_load),
    .drip_count (drip_count),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .ack        (ack),
    .c_out      (c_out)
  );

  always #5 clk = ~clk;

  // Dripper at count k presents row i element k-1-i on lane i (zero outside range).
  function automatic logic [4*DW-1:0] drip_rows(int k);
    logic [4*DW-1:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = k - 1 - i;
      if (idx >= 0 && idx < 4) v[i*DW +: DW] = la[i][idx];
    end
    return v;
  endfunction

  function automatic logic [4*DW-1:0] drip_cols(int k);
    logic [4*DW-1:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      int idx;
      idx = k - 1 - j;
      if (idx >= 0 && idx < 4) v[j*DW +: DW] = lb[idx][j];
    end
    return v;
  endfunction

  // Registered dripper pair: latch on load, emit on nonzero count, else hold stale.
  always @(posedge clk) begin
    if (drip_load) begin
      la <= ma;
      lb <= mb;
    end else if (drip_count != '0) begin
      a_in <= drip_rows(int'(drip_count));
      b_in <= drip_cols(int'(drip_count));
    end
  end

  task automatic compute_ref();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) s = s + ma[i][k] * mb[k][j];
        ref_c[i][j] = s;
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = $urandom;
        mb[i][j] = $urandom;
      end
  endtask

  task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = av;
        mb[i][j] = bv;
      end
  endtask

  // Called at a negedge in IDLE or DONE; returns at the negedge where done rises.
  task automatic run_op(input bit extra_starts, input string tag);
    int n;
    int loads;
    bit seq_bad;
    logic [CNT_W-1:0] exp_cnt;
    compute_ref();
    n = 0;
    loads = 0;
    seq_bad = 1'b0;
    start = 1'b1;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = extra_starts && (n == 4 || n == 11);
      if (drip_load) loads++;
      exp_cnt = (n >= 2 && n <= 8) ? CNT_W'(n - 1) : '0;
      if (drip_count !== exp_cnt) seq_bad = 1'b1;
      if (busy !== (n <= 15)) seq_bad = 1'b1;
      if (done) break;
    end
    start = 1'b0;
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles, expected 16", tag, n);
    end
    vectors++;
    if (loads != 1) begin
      miscompares++;
      $display("FAIL %s drip_load pulses: got %0d, expected 1", tag, loads);
    end
    vectors++;
    if (seq_bad) begin
      miscompares++;
      $display("FAIL %s drip_count/busy sequence: deviated from 1..7 then 0, got 1, expected 0", tag);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (c_out[(4*i+j)*DW +: DW] !== ref_c[i][j]) begin
          miscompares++;
          $display("FAIL %s C[%0d][%0d]: got %h, expected %h", tag, i, j,
                   c_out[(4*i+j)*DW +: DW], ref_c[i][j]);
        end
      end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({done, busy, drip_load, drip_count} !== '0 || c_out !== '0) begin
      miscompares++;
      $display("FAIL reset: got done=%b busy=%b load=%b cnt=%0d c_nonzero=%b, expected all 0",
               done, busy, drip_load, drip_count, |c_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = (i == j) ? 32'd1 : 32'd0;
        mb[i][j] = 32'(4*i + j + 1);
      end
    run_op(1'b0, "identity");
    do_ack();
  endtask

  task automatic test_signed_wrap();
    fill_const(32'h7FFF_FFFF, 32'd2);
    run_op(1'b0, "wrap_max");
    vectors++;
    if (c_out[0 +: DW] !== 32'hFFFF_FFF8) begin
      miscompares++;
      $display("FAIL wrap_max C00 const: got %h, expected fffffff8", c_out[0 +: DW]);
    end
    do_ack();
    fill_const(32'hFFFF_FFFF, 32'd3);
    run_op(1'b0, "neg_one");
    vectors++;
    if (c_out[15*DW +: DW] !== 32'hFFFF_FFF4) begin
      miscompares++;
      $display("FAIL neg_one C33 const: got %h, expected fffffff4", c_out[15*DW +: DW]);
    end
    do_ack();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_op(1'b0, "random");
      if (r[0]) do_ack();
    end
    do_ack();
  endtask

  task automatic test_handshake();
    logic [16*DW-1:0] snap;
    bit unstable;
    fill_random();
    run_op(1'b0, "hs_first");
    snap = c_out;
    unstable = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b1 || c_out !== snap) unstable = 1'b1;
    end
    vectors++;
    if (unstable) begin
      miscompares++;
      $display("FAIL hs_hold: done/c_out changed without ack, got 1, expected 0");
    end
    do_ack();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hs_ack_idle: got done=%b busy=%b, expected 0 0", done, busy);
    end
    fill_random();
    run_op(1'b0, "hs_second");
    fill_random();
    compute_ref();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || drip_load !== 1'b1) begin
      miscompares++;
      $display("FAIL hs_restart: got done=%b busy=%b load=%b, expected 0 1 1", done, busy, drip_load);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (c_out !== '0) begin
      miscompares++;
      $display("FAIL hs_cleared: got c_out nonzero=%b, expected 0", |c_out);
    end
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (c_out[(4*i+j)*DW +: DW] !== ref_c[i][j]) begin
          miscompares++;
          $display("FAIL hs_restart C[%0d][%0d]: got %h, expected %h", i, j,
                   c_out[(4*i+j)*DW +: DW], ref_c[i][j]);
        end
      end
    do_ack();
  endtask

  task automatic test_ignored_start();
    fill_random();
    run_op(1'b1, "ignored_start");
    do_ack();
  endtask

  task automatic test_reset_midop();
    int n;
    fill_random();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (drip_count != CNT_W'(4) && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    vectors++;
    if (drip_count !== CNT_W'(4)) begin
      miscompares++;
      $display("FAIL midop_reach: got count %0d, expected 4", drip_count);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({done, busy, drip_load, drip_count} !== '0 || c_out !== '0) begin
      miscompares++;
      $display("FAIL midop_reset: got done=%b busy=%b load=%b cnt=%0d c_nonzero=%b, expected all 0",
               done, busy, drip_load, drip_count, |c_out);
    end
    fill_random();
    run_op(1'b0, "after_reset");
    do_ack();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_signed_wrap();
    test_random();
    test_handshake();
    test_ignored_start();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
